// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Pops the oldest entry on resolution,
// emits a registered BHT update, flushes younger entries on mispredict, and keeps accuracy counters.
module branch_resolve_queue #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic                       upd_mispredict,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           correct_cnt,
  output logic                       underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [OCC_W-1:0] occ_nxt;
  logic             ready_en;

  logic             do_pop;
  logic             do_push;
  logic             mispredict;
  logic [PC_W-1:0]  head_pc;
  logic             head_pred;

  // ready_en keeps pred_ready low while in reset and until the first edge after release
  assign pred_ready = ready_en && (occupancy != OCC_FULL);

  assign head_pc    = pc_mem[rd_ptr];
  assign head_pred  = pred_mem[rd_ptr];
  assign do_pop     = res_valid && (occupancy != '0);
  assign mispredict = do_pop && (head_pred != res_taken);
  // a push alongside a mispredicting pop belongs to the wrong path and is dropped
  assign do_push    = pred_valid && pred_ready && !mispredict;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occupancy;
    if (mispredict) begin
      rd_ptr_nxt = wr_ptr;
      occ_nxt    = '0;
    end else begin
      if (do_push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)
        occ_nxt = occupancy + OCC_W'(1);
      else if (!do_push && do_pop)
        occ_nxt = occupancy - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= pred_pc;
      pred_mem[wr_ptr] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ready_en  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      occupancy <= occ_nxt;
      ready_en  <= 1'b1;
    end
  end

  // update payload holds its last value between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
      flush          <= 1'b0;
    end else begin
      upd_valid <= do_pop;
      flush     <= mispredict;
      if (do_pop) begin
        upd_pc         <= head_pc;
        upd_taken      <= res_taken;
        upd_mispredict <= mispredict;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_cnt   <= '0;
      correct_cnt <= '0;
    end else if (do_pop) begin
      if (total_cnt != CNT_MAX)
        total_cnt <= total_cnt + CNT_W'(1);
      if (!mispredict && (correct_cnt != CNT_MAX))
        correct_cnt <= correct_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underflow_err <= 1'b0;
    else if (res_valid && (occupancy == '0))
      underflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: per-cycle vector table plus hand sequences
// for reset, fill/wrap, underflow and counter saturation (second instance with CNT_W=4).
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid, pred_taken, res_valid, res_taken;
  logic [8:0] pred_pc;

  logic        pred_ready, upd_valid, upd_taken, upd_mispredict, flush, underflow_err;
  logic [8:0]  upd_pc;
  logic [3:0]  occupancy;
  logic [31:0] total_cnt, correct_cnt;

  logic        n_pred_ready, n_upd_valid, n_upd_taken, n_upd_mispredict, n_flush, n_underflow_err;
  logic [8:0]  n_upd_pc;
  logic [3:0]  n_occupancy;
  logic [3:0]  n_total_cnt, n_correct_cnt;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.PC_W(9), .DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .flush(flush), .occupancy(occupancy), .total_cnt(total_cnt), .correct_cnt(correct_cnt),
    .underflow_err(underflow_err)
  );

  branch_resolve_queue #(.PC_W(9), .DEPTH(8), .CNT_W(4)) dut_narrow (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(n_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(n_upd_valid), .upd_pc(n_upd_pc), .upd_taken(n_upd_taken), .upd_mispredict(n_upd_mispredict),
    .flush(n_flush), .occupancy(n_occupancy), .total_cnt(n_total_cnt), .correct_cnt(n_correct_cnt),
    .underflow_err(n_underflow_err)
  );

  typedef struct {
    logic       pv;
    logic [8:0] ppc;
    logic       pt;
    logic       rv;
    logic       rt;
    logic       e_uv;
    logic [8:0] e_pc;
    logic       e_ut;
    logic       e_mis;
    logic       e_fl;
    logic [3:0] e_occ;
    logic       e_rdy;
    int         e_tot;
    int         e_cor;
  } vec_t;

  vec_t vecs[12];
  logic [8:0] exp_q[$];
  logic [8:0] exp_pc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [8:0] ppc, input logic pt,
                       input logic rv, input logic rt);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt;
    res_valid  = rv; res_taken = rt;
  endtask

  function automatic vec_t mk(input logic pv, input logic [8:0] ppc, input logic pt,
                              input logic rv, input logic rt, input logic e_uv,
                              input logic [8:0] e_pc, input logic e_ut, input logic e_mis,
                              input logic e_fl, input logic [3:0] e_occ, input logic e_rdy,
                              input int e_tot, input int e_cor);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pt = pt; v.rv = rv; v.rt = rt;
    v.e_uv = e_uv; v.e_pc = e_pc; v.e_ut = e_ut; v.e_mis = e_mis; v.e_fl = e_fl;
    v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_tot = e_tot; v.e_cor = e_cor;
    return v;
  endfunction

  initial begin
    //             pv ppc    pt rv rt | uv pc     ut mis fl occ rdy tot cor
    vecs[0]  = mk(1, 9'h010, 1, 0, 0,  0, 9'h000, 0, 0, 0, 1, 1, 0, 0);
    vecs[1]  = mk(1, 9'h020, 0, 0, 0,  0, 9'h000, 0, 0, 0, 2, 1, 0, 0);
    vecs[2]  = mk(0, 9'h000, 0, 1, 1,  1, 9'h010, 1, 0, 0, 1, 1, 1, 1);
    vecs[3]  = mk(0, 9'h000, 0, 1, 0,  1, 9'h020, 0, 0, 0, 0, 1, 2, 2);
    vecs[4]  = mk(0, 9'h000, 0, 0, 0,  0, 9'h020, 0, 0, 0, 0, 1, 2, 2);
    vecs[5]  = mk(1, 9'h030, 1, 0, 0,  0, 9'h020, 0, 0, 0, 1, 1, 2, 2);
    vecs[6]  = mk(1, 9'h040, 1, 0, 0,  0, 9'h020, 0, 0, 0, 2, 1, 2, 2);
    vecs[7]  = mk(1, 9'h050, 0, 0, 0,  0, 9'h020, 0, 0, 0, 3, 1, 2, 2);
    vecs[8]  = mk(1, 9'h060, 1, 1, 0,  1, 9'h030, 0, 1, 1, 0, 1, 3, 2);
    vecs[9]  = mk(0, 9'h000, 0, 0, 0,  0, 9'h030, 0, 1, 0, 0, 1, 3, 2);
    vecs[10] = mk(1, 9'h070, 0, 0, 0,  0, 9'h030, 0, 1, 0, 1, 1, 3, 2);
    vecs[11] = mk(0, 9'h000, 0, 1, 0,  1, 9'h070, 0, 0, 0, 0, 1, 4, 3);

    reset = 1'b1;
    drive(0, 9'h000, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    step();

    // async reset mid-stream with 3 entries held and an update strobe live
    drive(1, 9'h011, 1, 0, 0); step();
    drive(1, 9'h012, 1, 0, 0); step();
    drive(1, 9'h013, 1, 0, 0); step();
    drive(1, 9'h014, 1, 1, 1); step();
    drive(0, 9'h000, 0, 0, 0);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    check("pre_rst_uv", 32'(upd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_uv", 32'(upd_valid), 32'd0);
    check("rst_upc", 32'(upd_pc), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_tot", total_cnt, 32'd0);
    check("rst_ready_in_reset", 32'(pred_ready), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("rst_ready_after", 32'(pred_ready), 32'd1);
    check("rst_occ_after", 32'(occupancy), 32'd0);
    check("rst_uf", 32'(underflow_err), 32'd0);

    // basic resolves, mispredict flush and dropped wrong-path push
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].rv, vecs[i].rt);
      step();
      check($sformatf("v%0d_uv", i),  32'(upd_valid),      32'(vecs[i].e_uv));
      check($sformatf("v%0d_pc", i),  32'(upd_pc),         32'(vecs[i].e_pc));
      check($sformatf("v%0d_ut", i),  32'(upd_taken),      32'(vecs[i].e_ut));
      check($sformatf("v%0d_mis", i), 32'(upd_mispredict), 32'(vecs[i].e_mis));
      check($sformatf("v%0d_fl", i),  32'(flush),          32'(vecs[i].e_fl));
      check($sformatf("v%0d_occ", i), 32'(occupancy),      32'(vecs[i].e_occ));
      check($sformatf("v%0d_rdy", i), 32'(pred_ready),     32'(vecs[i].e_rdy));
      check($sformatf("v%0d_tot", i), total_cnt,           32'(vecs[i].e_tot));
      check($sformatf("v%0d_cor", i), correct_cnt,         32'(vecs[i].e_cor));
    end
    drive(0, 9'h000, 0, 0, 0);

    // fill, overflow push, push+pop while full, pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1, 9'(i), 1, 0, 0);
      step();
      exp_q.push_back(9'(i));
    end
    check("full_occ", 32'(occupancy), 32'd8);
    check("full_ready", 32'(pred_ready), 32'd0);
    drive(1, 9'h1FF, 1, 0, 0); step();
    check("ovf_occ", 32'(occupancy), 32'd8);
    drive(1, 9'h1EE, 1, 1, 1); step();
    exp_pc = exp_q.pop_front();
    check("fullpp_uv", 32'(upd_valid), 32'd1);
    check("fullpp_pc", 32'(upd_pc), 32'(exp_pc));
    check("fullpp_occ", 32'(occupancy), 32'd7);
    check("fullpp_ready", 32'(pred_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      drive(1, 9'h100 + 9'(k), 1, 1, 1);
      step();
      exp_pc = exp_q.pop_front();
      exp_q.push_back(9'h100 + 9'(k));
      check($sformatf("wrap%0d_pc", k), 32'(upd_pc), 32'(exp_pc));
      check($sformatf("wrap%0d_occ", k), 32'(occupancy), 32'd7);
    end
    while (exp_q.size() > 0) begin
      drive(0, 9'h000, 0, 1, 1);
      step();
      exp_pc = exp_q.pop_front();
      check("drain_uv", 32'(upd_valid), 32'd1);
      check("drain_pc", 32'(upd_pc), 32'(exp_pc));
    end
    drive(0, 9'h000, 0, 0, 0); step();
    check("drain_occ", 32'(occupancy), 32'd0);

    // resolve on empty queue with a same-cycle push
    drive(1, 9'h0AA, 1, 1, 1); step();
    check("uf_uv", 32'(upd_valid), 32'd0);
    check("uf_err", 32'(underflow_err), 32'd1);
    check("uf_occ", 32'(occupancy), 32'd1);
    drive(0, 9'h000, 0, 0, 0); step(); step();
    check("uf_sticky", 32'(underflow_err), 32'd1);
    drive(0, 9'h000, 0, 1, 1); step();
    check("uf_pop_uv", 32'(upd_valid), 32'd1);
    check("uf_pop_pc", 32'(upd_pc), 32'h0AA);
    check("uf_pop_mis", 32'(upd_mispredict), 32'd0);
    check("uf_sticky2", 32'(underflow_err), 32'd1);
    drive(0, 9'h000, 0, 0, 0);
    reset = 1'b1; step();
    reset = 1'b0; step();
    check("uf_cleared", 32'(underflow_err), 32'd0);

    // counter saturation on the CNT_W=4 instance
    drive(1, 9'h005, 1, 0, 0); step();
    for (int k = 0; k < 20; k++) begin
      drive(1, 9'h006 + 9'(k), 1, 1, 1);
      step();
      if (k == 14) begin
        check("sat_n_tot15", 32'(n_total_cnt), 32'd15);
        check("sat_n_cor15", 32'(n_correct_cnt), 32'd15);
      end
    end
    drive(0, 9'h000, 0, 0, 0); step();
    check("sat_n_tot", 32'(n_total_cnt), 32'd15);
    check("sat_n_cor", 32'(n_correct_cnt), 32'd15);
    check("sat_w_tot", total_cnt, 32'd20);
    check("sat_w_cor", correct_cnt, 32'd20);
    check("sat_occ", 32'(occupancy), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
